// File: rtl/afifo_shadow_loader_pkg.sv
// Shared definitions for the activation FIFO pair: loader state encoding
// and the count-width helper used by the loader, double AFIFO and PE top.
package afifo_shadow_loader_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_SWAP = 2'd2
    } loader_state_e;

    // Width needed to hold a count from 0 up to and including depth.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/afifo_shadow_loader_if.sv
// Upstream activation stream plus the shadow FIFO write port.
// slave = the loader, master = the surrounding environment.
interface afifo_shadow_loader_if #(
    parameter int data_width = 17
);
    logic [data_width-1:0] src_data;
    logic                  src_valid;
    logic                  src_ready;
    logic [data_width-1:0] shadow_AFIFO_data_in;
    logic                  shadow_AFIFO_write;

    modport master (
        output src_data, src_valid,
        input  src_ready, shadow_AFIFO_data_in, shadow_AFIFO_write
    );

    modport slave (
        input  src_data, src_valid,
        output src_ready, shadow_AFIFO_data_in, shadow_AFIFO_write
    );
endinterface

// File: rtl/afifo_shadow_loader.sv
// Write-side controller for a double-buffered activation FIFO pair: loads a
// tile into the shadow FIFO, then swaps the pair once compute has drained.
module afifo_shadow_loader
    import afifo_shadow_loader_pkg::*;
#(
    parameter int nb_data    = 8,
    parameter int data_width = 17,
    parameter int CNT_W      = cnt_width(nb_data)
) (
    input  logic                 clk,
    input  logic                 rst,
    afifo_shadow_loader_if.slave bus,
    input  logic                 tile_start,
    input  logic [CNT_W-1:0]     tile_len,
    input  logic                 compute_done,
    input  logic                 compute_AFIFO_empty,
    output logic                 which_AFIFO_for_compute,
    output logic                 swap_pulse,
    output logic [CNT_W-1:0]     load_cnt,
    output logic                 busy
);

    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(nb_data);

    loader_state_e         state_q;
    loader_state_e         state_d;
    logic [CNT_W-1:0]      len_q;
    logic [CNT_W-1:0]      len_clamped;
    logic                  done_seen_q;
    logic                  src_ready_c;
    logic                  accept;
    logic                  last_accept;
    logic                  tile_accept;
    logic                  swap_fire;
    logic [data_width-1:0] src_word;
    logic [data_width-1:0] wr_data_q;
    logic                  wr_q;

    assign src_word    = bus.src_data;
    assign len_clamped = (tile_len > DEPTH) ? DEPTH : tile_len;
    assign last_accept = accept && ((load_cnt + CNT_W'(1)) == len_q);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (tile_start) state_d = (len_clamped == '0) ? WAIT_SWAP : LOAD;
            end
            LOAD: begin
                if (last_accept || (load_cnt >= len_q)) state_d = WAIT_SWAP;
            end
            WAIT_SWAP: begin
                if (swap_fire) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State-decoded outputs and strobes.
    always_comb begin
        src_ready_c = (state_q == LOAD) && (load_cnt < len_q);
        busy        = (state_q != IDLE);
        accept      = src_ready_c && bus.src_valid;
        tile_accept = (state_q == IDLE) && tile_start;
        swap_fire   = (state_q == WAIT_SWAP) && done_seen_q && compute_AFIFO_empty;
    end

    assign bus.src_ready            = src_ready_c;
    assign bus.shadow_AFIFO_write   = wr_q;
    assign bus.shadow_AFIFO_data_in = wr_data_q;

    // Latch the clamped tile length when a tile is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              len_q <= '0;
        else if (tile_accept) len_q <= len_clamped;
    end

    // Words written in the current tile; restarts on a new tile or a swap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           load_cnt <= '0;
        else if (swap_fire || tile_accept) load_cnt <= '0;
        else if (accept)                   load_cnt <= load_cnt + CNT_W'(1);
    end

    // Registered write port: one cycle from handshake to strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q      <= 1'b0;
            wr_data_q <= '0;
        end else begin
            wr_q <= accept;
            if (accept) wr_data_q <= src_word;
        end
    end

    // FIFO select toggles on a swap, with a matching one-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            which_AFIFO_for_compute <= 1'b0;
            swap_pulse              <= 1'b0;
        end else begin
            swap_pulse <= swap_fire;
            if (swap_fire) which_AFIFO_for_compute <= ~which_AFIFO_for_compute;
        end
    end

    // Sticky compute-finished flag; a compute_done coincident with a swap wins over the clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)               done_seen_q <= 1'b1;
        else if (compute_done) done_seen_q <= 1'b1;
        else if (swap_fire)    done_seen_q <= 1'b0;
    end

endmodule

// File: tb/tb_afifo_shadow_loader.sv
// Self-checking bench for afifo_shadow_loader: randomized tiles, a tile-level
// reference model and a write scoreboard checked by an independent monitor.
module tb_afifo_shadow_loader;

    localparam int NB = 8;
    localparam int DW = 17;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          tile_start;
    logic [CW-1:0] tile_len;
    logic          compute_done;
    logic          compute_AFIFO_empty;
    logic          which;
    logic          swap;
    logic [CW-1:0] load_cnt;
    logic          busy;

    afifo_shadow_loader_if #(.data_width(DW)) bus ();

    afifo_shadow_loader #(
        .nb_data    (NB),
        .data_width (DW)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .bus                     (bus),
        .tile_start              (tile_start),
        .tile_len                (tile_len),
        .compute_done            (compute_done),
        .compute_AFIFO_empty     (compute_AFIFO_empty),
        .which_AFIFO_for_compute (which),
        .swap_pulse              (swap),
        .load_cnt                (load_cnt),
        .busy                    (busy)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (tile level) ----------------
    typedef struct {
        logic [DW-1:0] data;
        int unsigned   due;
    } wr_t;

    wr_t         exp_q[$];
    bit          m_active, m_wait, m_done, m_which, m_swap;
    int          m_len, m_cnt;
    int          wr_in_tile;
    int unsigned cyc = 0;

    always @(negedge clk) begin
        bit  swap_now;
        bit  exp_w;
        wr_t e;
        cyc++;
        if (rst) begin
            m_active = 0; m_wait = 0; m_done = 1; m_which = 0; m_swap = 0;
            m_len = 0; m_cnt = 0; wr_in_tile = 0;
            exp_q.delete();
        end else begin
            chk("src_ready", bus.src_ready, m_active && !m_wait);
            chk("busy", busy, m_active);
            chk("load_cnt", load_cnt, m_cnt);
            chk("which", which, m_which);
            chk("swap_pulse", swap, m_swap);

            exp_w = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            chk("wr_strobe", bus.shadow_AFIFO_write, exp_w);
            if (exp_w) begin
                e = exp_q.pop_front();
                if (bus.shadow_AFIFO_write) chk("wr_data", bus.shadow_AFIFO_data_in, e.data);
            end
            if (bus.shadow_AFIFO_write) begin
                wr_in_tile++;
                chk("tile_writes_within_depth", wr_in_tile <= NB, 1);
            end

            // advance the model with this cycle's inputs
            swap_now = m_wait && m_done && compute_AFIFO_empty;
            if (!m_active && tile_start) begin
                m_len      = (int'(tile_len) > NB) ? NB : int'(tile_len);
                m_cnt      = 0;
                m_active   = 1;
                m_wait     = (m_len == 0);
                wr_in_tile = 0;
            end else if (m_active && !m_wait && bus.src_valid) begin
                exp_q.push_back('{data: bus.src_data, due: cyc + 1});
                m_cnt++;
                if (m_cnt == m_len) m_wait = 1;
            end
            if (swap_now) begin
                m_which  = !m_which;
                m_active = 0;
                m_wait   = 0;
                m_cnt    = 0;
            end
            m_swap = swap_now;
            m_done = compute_done || (m_done && !swap_now);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_src_ready", bus.src_ready, 0);
        chk("rst_write", bus.shadow_AFIFO_write, 0);
        chk("rst_data", bus.shadow_AFIFO_data_in, 0);
        chk("rst_which", which, 0);
        chk("rst_swap", swap, 0);
        chk("rst_load_cnt", load_cnt, 0);
        chk("rst_busy", busy, 0);
        tile_start   = 1'b0;
        bus.src_valid = 1'b0;
        compute_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic load_tile(input int len, input int p_valid, input int done_at,
                             input int rst_at, input bit noise, input bit seq_data);
        int n;
        int w;
        int budget;
        bit dg;
        n = (len > NB) ? NB : len;
        w = 0;
        budget = 0;
        dg = 0;
        tile_start = 1'b1;
        tile_len   = CW'(len);
        step();
        tile_start = 1'b0;
        while (w < n && budget < 300) begin
            if (w == rst_at) begin
                do_reset();
                return;
            end
            bus.src_data  = seq_data ? DW'(w + 1) : DW'($urandom());
            bus.src_valid = ($urandom_range(99) < p_valid);
            if (w == done_at && !dg) begin
                compute_done = 1'b1;
                dg = 1;
            end
            if (noise && w < n - 1 && $urandom_range(3) == 0) begin
                tile_start = 1'b1;
                tile_len   = CW'($urandom_range(15));
            end
            @(negedge clk);
            if (bus.src_valid && bus.src_ready) w++;
            budget++;
            step();
            tile_start   = 1'b0;
            compute_done = 1'b0;
        end
        bus.src_valid = 1'b0;
        chk("words_loaded", w, n);
    endtask

    task automatic wait_idle(input int p_done, input int p_empty, input int budget);
        int k;
        k = 0;
        while (busy && k < budget) begin
            compute_done        = ($urandom_range(99) < p_done);
            compute_AFIFO_empty = ($urandom_range(99) < p_empty);
            step();
            k++;
        end
        compute_done = 1'b0;
        chk("idle_within_budget", busy, 0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst                 = 1'b1;
        tile_start          = 1'b0;
        tile_len            = '0;
        bus.src_data        = '0;
        bus.src_valid       = 1'b0;
        compute_done        = 1'b0;
        compute_AFIFO_empty = 1'b1;
        #1;
        do_reset();

        // tile of 4 sequential words, done_seen set from reset
        load_tile(4, 100, -1, -1, 0, 1);
        wait_idle(0, 100, 20);

        // intermittent valid, needs a compute_done to swap
        load_tile(3, 50, -1, -1, 0, 1);
        wait_idle(30, 100, 100);

        // compute FIFO not empty: hold in WAIT_SWAP until both conditions meet
        compute_AFIFO_empty = 1'b0;
        load_tile(5, 100, -1, -1, 0, 0);
        repeat (5) step();
        compute_done = 1'b1;
        step();
        compute_done = 1'b0;
        repeat (4) step();
        compute_AFIFO_empty = 1'b1;
        repeat (3) step();

        // compute_done arrives mid-load; exactly one swap afterwards
        load_tile(6, 100, 2, -1, 0, 0);
        repeat (6) step();
        chk("single_swap_idle", busy, 0);

        // zero-length tile, then an over-length tile clamped to depth
        load_tile(0, 100, -1, -1, 0, 0);
        wait_idle(30, 100, 100);
        load_tile(12, 80, -1, -1, 0, 0);
        wait_idle(30, 100, 100);

        // reset mid-tile, clean reload, then ignored tile_start during LOAD
        load_tile(5, 100, -1, 2, 0, 0);
        load_tile(2, 100, -1, -1, 0, 1);
        wait_idle(30, 100, 100);
        load_tile(6, 60, -1, -1, 1, 0);
        wait_idle(30, 100, 100);

        // randomized tiles
        for (int i = 0; i < 25; i++) begin
            load_tile(int'($urandom_range(12)), int'($urandom_range(100, 30)),
                      int'($urandom_range(8)) - 1, -1, 1, 0);
            wait_idle(25, 60, 300);
        end

        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
